image_pixel_streamer: RTL
=========================

# image_pixel_streamer

Sequencer between the image BRAM and the first neural-network layer. On a start pulse it walks BRAM read addresses 0..IMG_PIXELS-1, absorbs the BRAM's one-cycle registered read latency, and presents pixels as a valid/ready stream. A two-entry output buffer carries the stream, so downstream backpressure never drops or duplicates a pixel. It pulses done once the last pixel has been accepted.

## Interface
- DATA_WIDTH, 8, pixel width; matches the BRAM data width.
- ADDR_WIDTH, 10, BRAM address width.
- IMG_PIXELS, 784, pixels per image (28*28); must be ≤ 2^ADDR_WIDTH.

- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to stream one image; ignored while busy.
- busy  out  1  high from the cycle after an accepted start until the cycle done pulses.
- done  out  1  one-cycle pulse after the last pixel handshake.
- bram_read_addr  out  ADDR_WIDTH  registered address to the BRAM read port.
- bram_read_data  in  DATA_WIDTH  BRAM registered read data, valid one cycle after its address.
- pix_valid  out  1  output pixel valid.
- pix_ready  in  1  downstream accepts the pixel when it is high together with pix_valid.
- pix_data  out  DATA_WIDTH  pixel value.
- pix_index  out  ADDR_WIDTH  index (0..IMG_PIXELS-1) of the pixel on pix_data.
- pix_last  out  1  high with pix_valid when pix_index == IMG_PIXELS-1.

## Operation
- **States:**
  - IDLE → STREAM on start.
  - STREAM → DRAIN when the read for address IMG_PIXELS-1 has been issued.
  - DRAIN → IDLE on the handshake with pix_last; done pulses on that transition.
- **Read issue:** a read is issued in STREAM when (occupancy + in_flight − pop) < 2.
  - pop = pix_valid && pix_ready.
  - in_flight is a 1-bit register set in the cycle after an issue. It marks bram_read_data for capture into the buffer on the next edge.
- **Address register:**
  - On an issue it advances by 1.
  - With no issue it holds its value; the BRAM has no enable, and un-flagged data is ignored.
  - It clears to 0 on an accepted start.
- **Output buffer:** 2-entry FIFO of {data, index}.
  - pix_valid = (occupancy != 0).
  - Push and pop in the same cycle are legal, including at occupancy 2 (pop first).
- **Accepted start:** a start in IDLE clears the address register, pixel counter and buffer.
- **Downstream stall:** with pix_ready held low, at most 2 pixels are buffered. No further reads are issued and bram_read_addr freezes.
- **Counters:** the pixel index wraps nowhere; it counts 0..IMG_PIXELS-1 and stops. Counter width is ADDR_WIDTH; no arithmetic overflow is possible given the IMG_PIXELS bound.
- **Reset mid-operation:** the block returns to IDLE immediately, the buffer empties, and no done pulse is generated.

## Timing
- **Reset values:** busy=0, done=0, pix_valid=0, pix_data=0, pix_index=0, pix_last=0, bram_read_addr=0.
- **Start latency (cycle numbering from start sampled in cycle 0):**
  - cycle 1: busy=1, bram_read_addr=0.
  - cycle 2: bram_read_data=mem[0].
  - cycle 3: pix_valid=1, pix_data=mem[0], pix_index=0.
- **Throughput:** with pix_ready held high, one pixel per cycle.
  - Pixel 783 is presented in cycle 786 with pix_last=1.
  - done=1 and busy still 1 in cycle 787; busy=0 from cycle 788.
- **Back-to-back:** a start in the done cycle is ignored; the earliest accepted start is in cycle 788.
- **Stall release:** pix_ready rising after a stall yields a valid pixel every cycle, with no bubble beyond the first refill cycle.
- **Output stability:** pix_data, pix_index and pix_last are stable while pix_valid=1 and pix_ready=0.

## Structure
- **image_pkg:** IMG_PIXELS, IMG_DATA_WIDTH and IMG_ADDR_WIDTH constants, plus the state enum (IDLE, STREAM, DRAIN). The same constants are shared with the BRAM instance and the loader.
- **pixel_skid_fifo:** one sub-module, a 2-entry synchronous FIFO parameterised on width. It exposes occupancy and is instantiated for {data, index}.
- **Top level:** the FSM, address register, in-flight flag and done logic live in the top module.

## Test plan
- BRAM preloaded with mem[i]=i[7:0], pix_ready=1, start pulse → 784 pixels in consecutive cycles 3..786, data == index[7:0], pix_last only on index 783, done pulse in cycle 787.
- pix_ready random at 50% → sequence 0..783 complete, no gaps, no repeats. bram_read_addr never more than 2 ahead of the last accepted index + 1.
- pix_ready low for 20 cycles starting at cycle 5 → occupancy stays 2, bram_read_addr frozen, pix_data unchanged; stream resumes correctly after release.
- start pulsed at cycle 100 of a run → ignored, single done, total pixel count 784.
- rst asserted at cycle 400 mid-stream → all outputs at reset values by the next cycle, no done; a new start streams index 0..783 cleanly.
- pix_ready toggling 1/0 every cycle around index 782..783 → pix_last accepted exactly once; done one cycle after that handshake.

Source files
------------

// File: rtl/image_pkg.sv
// Shared image geometry and streamer state encoding, also used by the BRAM instance and loader.
package image_pkg;

  localparam int unsigned IMG_PIXELS     = 784;
  localparam int unsigned IMG_DATA_WIDTH = 8;
  localparam int unsigned IMG_ADDR_WIDTH = 10;

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DRAIN
  } state_t;

endpackage

// File: rtl/pixel_skid_fifo.sv
// Two-entry FIFO with the head held in entry 0, so dout comes straight from a register.
module pixel_skid_fifo #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic [1:0]       occupancy
);

  logic [WIDTH-1:0] mem0;
  logic [WIDTH-1:0] mem1;

  // Callers never pop when empty nor push when full without popping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem0      <= '0;
      mem1      <= '0;
      occupancy <= 2'd0;
    end else if (flush) begin
      occupancy <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (occupancy == 2'd0) mem0 <= din;
          else                   mem1 <= din;
          occupancy <= occupancy + 2'd1;
        end
        2'b01: begin
          mem0      <= mem1;
          occupancy <= occupancy - 2'd1;
        end
        2'b11: begin
          if (occupancy == 2'd2) begin
            mem0 <= mem1;
            mem1 <= din;
          end else begin
            mem0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign dout = mem0;

endmodule

// File: rtl/image_pixel_streamer.sv
// Walks the image BRAM on start and presents its pixels as a valid/ready stream with done.
module image_pixel_streamer
  import image_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = image_pkg::IMG_DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH = image_pkg::IMG_ADDR_WIDTH,
  parameter int unsigned IMG_PIXELS = image_pkg::IMG_PIXELS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [ADDR_WIDTH-1:0] bram_read_addr,
  input  logic [DATA_WIDTH-1:0] bram_read_data,
  output logic                  pix_valid,
  input  logic                  pix_ready,
  output logic [DATA_WIDTH-1:0] pix_data,
  output logic [ADDR_WIDTH-1:0] pix_index,
  output logic                  pix_last
);

  localparam int unsigned PW = DATA_WIDTH + ADDR_WIDTH + 1;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(IMG_PIXELS - 1);

  state_t                state_q, state_d;
  logic                  in_flight;
  logic [ADDR_WIDTH-1:0] pix_cnt;
  logic [1:0]            occupancy;
  logic [2:0]            pending;
  logic                  accept_start, issue, pop;
  logic                  done_d, busy_d;
  logic [PW-1:0]         fifo_din, fifo_dout;
  logic                  head_last;

  // A start landing in the done cycle must not re-arm the block.
  assign accept_start = (state_q == IDLE) && start && !done;
  assign pop          = pix_valid && pix_ready;
  assign pending      = 3'(occupancy) + 3'(in_flight) - 3'(pop);
  assign issue        = (state_q == STREAM) && (pending < 3'd2);

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE:    if (accept_start) state_d = STREAM;
      STREAM:  if (issue && (bram_read_addr == LAST_IDX)) state_d = DRAIN;
      DRAIN: begin
        if (pop && pix_last) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE) || done_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q        <= IDLE;
      in_flight      <= 1'b0;
      done           <= 1'b0;
      busy           <= 1'b0;
      bram_read_addr <= '0;
      pix_cnt        <= '0;
    end else begin
      state_q   <= state_d;
      in_flight <= issue;
      done      <= done_d;
      busy      <= busy_d;
      if (accept_start) begin
        bram_read_addr <= '0;
        pix_cnt        <= '0;
      end else begin
        if (issue)     bram_read_addr <= bram_read_addr + ADDR_WIDTH'(1);
        if (in_flight) pix_cnt        <= pix_cnt + ADDR_WIDTH'(1);
      end
    end
  end

  // Data flagged by in_flight belongs to the pixel counted by pix_cnt.
  assign fifo_din = {(pix_cnt == LAST_IDX), pix_cnt, bram_read_data};

  pixel_skid_fifo #(.WIDTH(PW)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .flush     (accept_start),
    .push      (in_flight),
    .din       (fifo_din),
    .pop       (pop),
    .dout      (fifo_dout),
    .occupancy (occupancy)
  );

  assign {head_last, pix_index, pix_data} = fifo_dout;
  assign pix_valid = (occupancy != 2'd0);
  assign pix_last  = pix_valid && head_last;

endmodule
